// File: rtl/nios2_debug_ocimem_pkg.sv
// Shared constants and types for the Nios II debug OCI memory controller.
package nios2_debug_ocimem_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_ADDR_LSB = 17;
    localparam int unsigned JDO_FLAG_BIT = 34;
    localparam int unsigned JDO_DATA_MSB = 34;
    localparam int unsigned JDO_DATA_LSB = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_CAP   = 2'd2,
        WR       = 2'd3
    } state_t;

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, one-cycle read latency, read-old on write.
module nios2_debug_ocimem_ram
    import nios2_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 32'(1) << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Decodes debug-slave ocimem commands into debug RAM accesses and arbitrates
// the RAM port against a CPU-side Avalon-MM slave (debug always wins).
module nios2_debug_ocimem_ctrl
    import nios2_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic              cpu_waitrequest
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [DATA_W-1:0] wdata_q, wdata_nxt;
    logic [DATA_W-1:0] mon_nxt;
    logic              error_nxt;
    logic              cpu_rd_pend;

    logic              strobe_any_c;
    logic              cpu_req_c;
    logic              cpu_accept_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] ram_q;
    logic              unused_jdo_c;

    assign unused_jdo_c = ^{jdo[JDO_W-1:JDO_DATA_MSB+1], jdo[JDO_DATA_LSB-1:0]};

    assign strobe_any_c    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign cpu_req_c       = cpu_read | cpu_write;
    assign cpu_accept_c    = cpu_req_c & (state == IDLE) & ~strobe_any_c;
    assign cpu_waitrequest = cpu_req_c & ((state != IDLE) | strobe_any_c);

    // Next-state, RAM port mux and register updates
    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        wdata_nxt   = wdata_q;
        mon_nxt     = MonDReg;
        error_nxt   = monitor_error;
        ram_we_c    = 1'b0;
        ram_addr_c  = cpu_address;
        ram_wdata_c = cpu_writedata;

        if ((state != IDLE) && strobe_any_c) begin
            error_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_nxt  = jdo[JDO_ADDR_LSB +: ADDR_W];
                    // Clear on load, but a dropped simultaneous strobe still sets it
                    error_nxt = take_action_ocimem_b | take_no_action_ocimem_a;
                    if (jdo[JDO_FLAG_BIT]) begin
                        state_nxt = RD_ISSUE;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_nxt = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
                    error_nxt = monitor_error | take_no_action_ocimem_a;
                    state_nxt = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt = RD_ISSUE;
                end else if (cpu_accept_c) begin
                    ram_we_c = cpu_write;
                end
            end
            RD_ISSUE: begin
                ram_addr_c = addr;
                state_nxt  = RD_CAP;
            end
            RD_CAP: begin
                mon_nxt   = ram_q;
                addr_nxt  = addr + ADDR_W'(1);
                state_nxt = IDLE;
            end
            WR: begin
                ram_we_c    = 1'b1;
                ram_addr_c  = addr;
                ram_wdata_c = wdata_q;
                addr_nxt    = addr + ADDR_W'(1);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            addr              <= '0;
            wdata_q           <= '0;
            MonDReg           <= '0;
            monitor_ready     <= 1'b1;
            monitor_error     <= 1'b0;
            cpu_rd_pend       <= 1'b0;
            cpu_readdata      <= '0;
            cpu_readdatavalid <= 1'b0;
        end else begin
            state             <= state_nxt;
            addr              <= addr_nxt;
            wdata_q           <= wdata_nxt;
            MonDReg           <= mon_nxt;
            monitor_ready     <= (state_nxt == IDLE);
            monitor_error     <= error_nxt;
            cpu_rd_pend       <= cpu_accept_c & cpu_read;
            cpu_readdatavalid <= cpu_rd_pend;
            if (cpu_rd_pend) begin
                cpu_readdata <= ram_q;
            end
        end
    end

    // Write enable is suppressed during reset so an abandoned write never lands
    nios2_debug_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_c & ~reset),
        .addr  (ram_addr_c),
        .wdata (ram_wdata_c),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Scoreboard bench for nios2_debug_ocimem_ctrl: directed debug/CPU traffic,
// expectations queued at issue time and checked by independent monitors.
module tb_nios2_debug_ocimem_ctrl;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;
    logic              cpu_waitrequest;

    typedef struct {
        logic [31:0] data;
        int          low;
    } dbg_exp_t;

    typedef struct {
        logic [31:0] data;
        int          acc;
    } cpu_exp_t;

    dbg_exp_t    dbg_q[$];
    cpu_exp_t    cpu_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        reset_q  = 1'b1;
    logic [31:0] mon_m    = 32'h0;

    nios2_debug_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .cpu_waitrequest         (cpu_waitrequest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        reset_q <= reset;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] jl(input logic [7:0] a, input logic f);
        logic [37:0] j;
        j        = '0;
        j[17+:8] = a;
        j[34]    = f;
        return j;
    endfunction

    function automatic logic [37:0] jw(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    // Debug monitor: each return of monitor_ready completes one queued command
    logic dm_prev = 1'b1;
    int   dm_low  = 0;
    always @(negedge clk) begin
        dbg_exp_t e;
        if (reset_q) begin
            dm_low = 0;
        end else if (!monitor_ready) begin
            dm_low++;
        end else if (!dm_prev) begin
            if (dbg_q.size() == 0) begin
                check32("dbg_spurious_done", 32'(dm_prev), 32'(1));
            end else begin
                e = dbg_q.pop_front();
                check32("MonDReg", MonDReg, e.data);
                check32("ready_low_cycles", 32'(dm_low), 32'(e.low));
            end
            dm_low = 0;
        end
        dm_prev = reset_q ? 1'b1 : monitor_ready;
    end

    // CPU monitor: each readdatavalid pulse completes one queued CPU read
    always @(negedge clk) begin
        cpu_exp_t e;
        if (cpu_readdatavalid) begin
            if (cpu_q.size() == 0) begin
                check32("cpu_spurious_valid", 32'(cpu_readdatavalid), 32'(0));
            end else begin
                e = cpu_q.pop_front();
                check32("cpu_readdata", cpu_readdata, e.data);
                check32("cpu_rd_latency", 32'(cyc), 32'(e.acc + 2));
            end
        end
    end

    task automatic pulse(input logic a, input logic n, input logic b, input logic [37:0] j);
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b    = b;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!monitor_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check32("ready_after_cmd", 32'(monitor_ready), 32'(1));
    endtask

    task automatic dbg_load(input logic [7:0] a, input logic rd, input logic [31:0] exp);
        if (rd) begin
            dbg_q.push_back('{exp, 2});
            mon_m = exp;
        end
        pulse(1'b1, 1'b0, 1'b0, jl(a, rd));
        wait_idle();
    endtask

    task automatic dbg_write(input logic [31:0] d);
        dbg_q.push_back('{mon_m, 1});
        pulse(1'b0, 1'b0, 1'b1, jw(d));
        wait_idle();
    endtask

    task automatic dbg_read(input logic [31:0] exp);
        dbg_q.push_back('{exp, 2});
        mon_m = exp;
        pulse(1'b0, 1'b1, 1'b0, '0);
        wait_idle();
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        int k = 0;
        cpu_address   = a;
        cpu_writedata = d;
        cpu_write     = 1'b1;
        #1;
        while (cpu_waitrequest && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check32("cpu_wr_accept", 32'(cpu_waitrequest), 32'(0));
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] a, input logic [31:0] exp);
        int k = 0;
        cpu_address = a;
        cpu_read    = 1'b1;
        #1;
        while (cpu_waitrequest && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check32("cpu_rd_accept", 32'(cpu_waitrequest), 32'(0));
        cpu_q.push_back('{exp, cyc});
        @(negedge clk);
        cpu_read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                   = 1'b1;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        cpu_address             = '0;
        cpu_read                = 1'b0;
        cpu_write               = 1'b0;
        cpu_writedata           = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check32("rst_MonDReg", MonDReg, 32'h0);
        check32("rst_ready", 32'(monitor_ready), 32'(1));
        check32("rst_error", 32'(monitor_error), 32'(0));
        check32("rst_cpu_readdata", cpu_readdata, 32'h0);
        check32("rst_cpu_valid", 32'(cpu_readdatavalid), 32'(0));
        check32("rst_waitrequest", 32'(cpu_waitrequest), 32'(0));
        @(negedge clk);

        cpu_wr(8'h00, 32'h0BADF00D);

        // Load, two writes, read-after-load, read; addr ends at 0x12
        dbg_load(8'h10, 1'b0, 32'h0);
        dbg_write(32'hDEADBEEF);
        dbg_write(32'h12345678);
        dbg_load(8'h10, 1'b1, 32'hDEADBEEF);
        dbg_read(32'h12345678);
        dbg_write(32'h11111111);
        cpu_rd(8'h12, 32'h11111111);
        cpu_rd(8'h10, 32'hDEADBEEF);

        // Address wrap
        dbg_load(8'hFF, 1'b0, 32'h0);
        dbg_write(32'hA5A5A5A5);
        dbg_read(32'h0BADF00D);
        cpu_rd(8'hFF, 32'hA5A5A5A5);

        // Write strobe while busy is dropped
        dbg_load(8'h10, 1'b0, 32'h0);
        dbg_q.push_back('{32'hDEADBEEF, 2});
        mon_m = 32'hDEADBEEF;
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        jdo = jw(32'h55555555);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        wait_idle();
        check32("busy_drop_error", 32'(monitor_error), 32'(1));
        cpu_rd(8'h11, 32'h12345678);
        dbg_load(8'h30, 1'b0, 32'h0);
        check32("error_cleared", 32'(monitor_error), 32'(0));

        // Simultaneous ocimem_a + ocimem_b
        cpu_wr(8'h30, 32'h33333333);
        cpu_wr(8'h40, 32'h77777777);
        pulse(1'b1, 1'b0, 1'b1, jl(8'h40, 1'b0));
        check32("collide_error", 32'(monitor_error), 32'(1));
        check32("collide_ready", 32'(monitor_ready), 32'(1));
        cpu_rd(8'h40, 32'h77777777);
        cpu_rd(8'h30, 32'h33333333);
        dbg_read(32'h77777777);

        // CPU read held against a debug write to the same word
        dbg_load(8'h20, 1'b0, 32'h0);
        dbg_q.push_back('{mon_m, 1});
        cpu_address = 8'h20;
        cpu_read = 1'b1;
        jdo = jw(32'hCAFEF00D);
        take_action_ocimem_b = 1'b1;
        #1;
        check32("wait_on_strobe", 32'(cpu_waitrequest), 32'(1));
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        #1;
        check32("wait_in_wr", 32'(cpu_waitrequest), 32'(1));
        check32("busy_ready_low", 32'(monitor_ready), 32'(0));
        cpu_rd(8'h20, 32'hCAFEF00D);

        // Reset in RD_CAP
        jdo = '0;
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        jdo = jw(32'h13572468);
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
        check32("pre_reset_error", 32'(monitor_error), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mon_m = 32'h0;
        check32("midrst_MonDReg", MonDReg, 32'h0);
        check32("midrst_ready", 32'(monitor_ready), 32'(1));
        check32("midrst_error", 32'(monitor_error), 32'(0));
        check32("midrst_cpu_readdata", cpu_readdata, 32'h0);
        dbg_read(32'h0BADF00D);

        repeat (5) @(negedge clk);
        check32("dbg_q_empty", 32'(dbg_q.size()), 32'(0));
        check32("cpu_q_empty", 32'(cpu_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
